// File: rtl/mobo_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// mobo_bus_responder_pkg
//
// Shared definitions for the motherboard bus: bit positions inside the CPU's
// mobo_ctrl command word and the responder's mobo_stat status word, plus the
// responder FSM state type. The cpu block imports the same package so both
// ends of the bus agree on the encoding.
// -----------------------------------------------------------------------------
package mobo_bus_responder_pkg;

    // mobo_ctrl bit positions (driven by the CPU)
    localparam int unsigned CTRL_REQ  = 0;  // request strobe, held for the whole handshake
    localparam int unsigned CTRL_WR   = 1;  // 1 = write, 0 = read

    // mobo_stat bit positions (driven by the responder)
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_RAM_RD = 3'd2,
        ST_VGA_WR = 3'd3,
        ST_DONE   = 3'd4
    } bus_state_e;

endpackage : mobo_bus_responder_pkg

// File: rtl/mobo_bus_responder_ram.sv
// -----------------------------------------------------------------------------
// mobo_bus_responder_ram
//
// Synchronous single-port word RAM. Writes land on the clock edge where we_i
// is high; reads are registered, so rdata_o shows mem[addr_i] one cycle after
// a cycle with en_i high.
//
// Ports
//   clk_i    clock
//   we_i     write enable
//   en_i     read enable (updates the read register)
//   addr_i   word address, ADDR_WIDTH bits
//   wdata_i  write data, WIDTH bits
//   rdata_o  registered read data, WIDTH bits
// -----------------------------------------------------------------------------
module mobo_bus_responder_ram #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; contents survive
    // a bus reset, which the CPU side relies on.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mobo_bus_responder_ram

// File: rtl/mobo_bus_responder.sv
// -----------------------------------------------------------------------------
// mobo_bus_responder
//
// Motherboard-side responder for the CPU bus. A request (mobo_ctrl[REQ]) is
// accepted only from IDLE; address, write data and direction are latched so
// the CPU may change them while busy. The latched address is decoded into the
// local word RAM (word address 0 upward), the VGA framebuffer window, or an
// error. Completion is reported with a four-phase busy/done handshake: done
// stays high until the CPU drops req.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   mobo_ctrl  CPU command: [0] req, [1] write/read; other bits ignored
//   mobo_stat  status: [0] busy, [1] done, [2] err; other bits 0
//   addr       CPU word address
//   cpu_wdata  CPU write data
//   cpu_rdata  read data, held until the next read completes
//   vga_we     framebuffer write strobe, held until vga_ready
//   vga_addr   framebuffer word offset
//   vga_data   framebuffer write data
//   vga_ready  framebuffer accepts the write this cycle
// -----------------------------------------------------------------------------
module mobo_bus_responder
    import mobo_bus_responder_pkg::*;
#(
    parameter int unsigned               WORD_WIDTH     = 32,
    parameter int unsigned               RAM_ADDR_WIDTH = 10,
    parameter int unsigned               RAM_RD_LAT     = 2,
    parameter logic [WORD_WIDTH-1:0]     VGA_BASE       = 32'h0001_0000,
    parameter int unsigned               VGA_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_WIDTH-1:0]     mobo_ctrl,
    output logic [WORD_WIDTH-1:0]     mobo_stat,
    input  logic [WORD_WIDTH-1:0]     addr,
    input  logic [WORD_WIDTH-1:0]     cpu_wdata,
    output logic [WORD_WIDTH-1:0]     cpu_rdata,
    output logic                      vga_we,
    output logic [VGA_ADDR_WIDTH-1:0] vga_addr,
    output logic [WORD_WIDTH-1:0]     vga_data,
    input  logic                      vga_ready
);

    // Wait counter only needs to hold RAM_RD_LAT-1.
    localparam int unsigned CNT_W = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    bus_state_e                  state_q;
    logic [WORD_WIDTH-1:0]       addr_q;
    logic [WORD_WIDTH-1:0]       wdata_q;
    logic                        wr_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;
    logic [WORD_WIDTH-1:0]       rdata_q;
    logic                        vga_we_q;
    logic [VGA_ADDR_WIDTH-1:0]   vga_addr_q;
    logic [WORD_WIDTH-1:0]       vga_data_q;

    // -------------------------------------------------------------------------
    // Address decode on the latched address. RAM is tested first in the FSM,
    // which gives it priority if the two windows ever overlap.
    // -------------------------------------------------------------------------
    logic ram_hit;
    logic vga_hit;

    assign ram_hit = (addr_q[WORD_WIDTH-1:RAM_ADDR_WIDTH] == '0);
    assign vga_hit = (addr_q[WORD_WIDTH-1:VGA_ADDR_WIDTH] ==
                      VGA_BASE[WORD_WIDTH-1:VGA_ADDR_WIDTH]);

    // -------------------------------------------------------------------------
    // Word RAM. The write fires on the DECODE edge; gating with rst keeps a
    // reset on that very edge from leaking a write. Reads are captured from
    // DECODE onward so data is ready when the latency counter expires.
    // -------------------------------------------------------------------------
    logic                  ram_we;
    logic                  ram_rd_en;
    logic [WORD_WIDTH-1:0] ram_rdata;

    assign ram_we    = (state_q == ST_DECODE) && wr_q && ram_hit && !rst;
    assign ram_rd_en = (state_q == ST_DECODE) || (state_q == ST_RAM_RD);

    mobo_bus_responder_ram #(
        .WIDTH      (WORD_WIDTH),
        .ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .en_i    (ram_rd_en),
        .addr_i  (addr_q[RAM_ADDR_WIDTH-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            vga_we_q   <= 1'b0;
            vga_addr_q <= '0;
            vga_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mobo_ctrl[CTRL_REQ]) begin
                        addr_q  <= addr;
                        wdata_q <= cpu_wdata;
                        wr_q    <= mobo_ctrl[CTRL_WR];
                        busy_q  <= 1'b1;
                        state_q <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (ram_hit) begin
                        if (wr_q) begin
                            // RAM write is performed on this edge by ram_we.
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q   <= CNT_W'(RAM_RD_LAT - 1);
                            state_q <= ST_RAM_RD;
                        end
                    end else if (vga_hit && wr_q) begin
                        vga_we_q   <= 1'b1;
                        vga_addr_q <= addr_q[VGA_ADDR_WIDTH-1:0];
                        vga_data_q <= wdata_q;
                        state_q    <= ST_VGA_WR;
                    end else begin
                        // Framebuffer is write-only; anything else is unmapped.
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end

                ST_RAM_RD: begin
                    if (cnt_q == '0) begin
                        rdata_q <= ram_rdata;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_VGA_WR: begin
                    // Beat is accepted on the first edge with vga_ready high;
                    // the strobe drops in the same step so only one beat goes out.
                    if (vga_ready) begin
                        vga_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Four-phase: wait for the CPU to drop req before re-arming.
                    if (!mobo_ctrl[CTRL_REQ]) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assign a default first so no path through the block leaves
        // bits unassigned and infers a latch.
        mobo_stat            = '0;
        mobo_stat[STAT_BUSY] = busy_q;
        mobo_stat[STAT_DONE] = done_q;
        mobo_stat[STAT_ERR]  = err_q;
    end

    assign cpu_rdata = rdata_q;
    assign vga_we    = vga_we_q;
    assign vga_addr  = vga_addr_q;
    assign vga_data  = vga_data_q;

    // Upper command bits are reserved on this bus.
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^mobo_ctrl[WORD_WIDTH-1:2];

endmodule : mobo_bus_responder

// File: tb/tb_mobo_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_mobo_bus_responder
//
// Scoreboard bench: the driver computes each transaction's expected outcome
// from a simple memory-map model and queues it; monitors compare when the DUT
// raises done or strobes vga_we.
// -----------------------------------------------------------------------------
module tb_mobo_bus_responder;

    localparam int unsigned  WW       = 32;
    localparam int unsigned  RAM_AW   = 10;
    localparam int unsigned  RD_LAT   = 2;
    localparam logic [31:0]  VBASE    = 32'h0001_0000;
    localparam int unsigned  VGA_AW   = 16;
    localparam longint       RAM_WORDS = longint'(1) << RAM_AW;
    localparam longint       VGA_WORDS = longint'(1) << VGA_AW;

    logic              clk = 1'b0;
    logic              rst;
    logic [WW-1:0]     mobo_ctrl;
    logic [WW-1:0]     mobo_stat;
    logic [WW-1:0]     addr;
    logic [WW-1:0]     cpu_wdata;
    logic [WW-1:0]     cpu_rdata;
    logic              vga_we;
    logic [VGA_AW-1:0] vga_addr;
    logic [WW-1:0]     vga_data;
    logic              vga_ready;

    mobo_bus_responder #(
        .WORD_WIDTH     (WW),
        .RAM_ADDR_WIDTH (RAM_AW),
        .RAM_RD_LAT     (RD_LAT),
        .VGA_BASE       (VBASE),
        .VGA_ADDR_WIDTH (VGA_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mobo_ctrl (mobo_ctrl),
        .mobo_stat (mobo_stat),
        .addr      (addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .vga_we    (vga_we),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_ready (vga_ready)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          start;
    } exp_t;

    typedef struct {
        logic [15:0] off;
        logic [31:0] data;
        int          we_cycles;   // -1: transaction will be aborted
    } vga_exp_t;

    typedef enum {R_RAM, R_VGA, R_NONE} region_e;

    exp_t        exp_q[$];
    vga_exp_t    vga_exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] wr_addrs[$];
    logic [31:0] last_rdata = '0;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic region_e region_of(input logic [31:0] a);
        longint la;
        la = longint'({32'b0, a});
        if (la < RAM_WORDS) return R_RAM;
        if (la >= longint'({32'b0, VBASE}) && la < longint'({32'b0, VBASE}) + VGA_WORDS) return R_VGA;
        return R_NONE;
    endfunction

    // ---------------- monitors ----------------
    logic done_prev = 1'b0;
    int   we_cnt    = 0;

    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
            we_cnt    = 0;
        end else begin
            if (mobo_stat[1] && !done_prev) begin
                check("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("err", 32'(mobo_stat[2]), 32'(e.err));
                    check("cpu_rdata", cpu_rdata, e.rdata);
                    check("latency", 32'(cycle_cnt - e.start), 32'(e.lat));
                    check("busy_at_done", 32'(mobo_stat[0]), 32'd0);
                end
            end
            done_prev = mobo_stat[1];

            if (vga_we) begin
                check("vga_we_expected", 32'(vga_exp_q.size() != 0), 32'd1);
                if (vga_exp_q.size() != 0) begin
                    we_cnt++;
                    check("vga_addr", 32'(vga_addr), 32'(vga_exp_q[0].off));
                    check("vga_data", vga_data, vga_exp_q[0].data);
                    if (vga_ready) begin
                        vga_exp_t v;
                        v = vga_exp_q.pop_front();
                        check("vga_we_cycles", 32'(we_cnt), 32'(v.we_cycles));
                        we_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scramble inputs the DUT must have latched; req is kept as is.
    task automatic jiggle();
        logic [31:0] t;
        t          = $urandom();
        t[0]       = mobo_ctrl[0];
        mobo_ctrl  = t;
        addr       = $urandom();
        cpu_wdata  = $urandom();
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] t;
        t         = $urandom();
        t[0]      = 1'b1;
        t[1]      = wr;
        mobo_ctrl = t;
        addr      = a;
        cpu_wdata = d;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stat"},     mobo_stat,        32'd0);
        check({tag, "_rdata"},    cpu_rdata,        32'd0);
        check({tag, "_vga_we"},   32'(vga_we),      32'd0);
        check({tag, "_vga_addr"}, 32'(vga_addr),    32'd0);
        check({tag, "_vga_data"}, vga_data,         32'd0);
    endtask

    // One complete four-phase transaction.
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int stall, input int hold);
        exp_t     e;
        vga_exp_t v;
        region_e  r;
        bit       got;
        r       = region_of(a);
        e.err   = 1'b0;
        e.lat   = 2;
        e.start = cycle_cnt;
        case (r)
            R_RAM: begin
                if (wr) begin
                    if (!mem_model.exists(a)) wr_addrs.push_back(a);
                    mem_model[a] = d;
                end else begin
                    last_rdata = mem_model[a];
                    e.lat      = 2 + int'(RD_LAT);
                end
            end
            R_VGA: begin
                if (wr) begin
                    v.off       = 16'(a - VBASE);
                    v.data      = d;
                    v.we_cycles = stall + 1;
                    vga_exp_q.push_back(v);
                    e.lat       = 3 + stall;
                end else begin
                    e.err = 1'b1;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.rdata = last_rdata;
        exp_q.push_back(e);

        if (r == R_VGA && wr && stall > 0) vga_ready = 1'b0;
        drive_req(wr, a, d);

        if (r == R_VGA && wr && stall > 0) begin
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                jiggle();
                if (vga_we) begin
                    got = 1'b1;
                    break;
                end
            end
            check("vga_we_seen", 32'(got), 32'd1);
            for (int i = 0; i < stall; i++) begin
                step();
                jiggle();
            end
            vga_ready = 1'b1;
        end

        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mobo_stat[1]) begin
                got = 1'b1;
                break;
            end
            step();
            jiggle();
        end
        check("done_seen", 32'(got), 32'd1);

        for (int i = 0; i < hold; i++) begin
            step();
            jiggle();
            check("no_retrigger", 32'(mobo_stat[2:0] & 3'b011), 32'b010);
        end

        mobo_ctrl[0] = 1'b0;
        step();
        check("done_clear", 32'(mobo_stat[2:0]), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        mobo_ctrl = '0;
        addr      = '0;
        cpu_wdata = '0;
        vga_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // RAM write then read
        run_txn(1'b1, 32'd3, 32'h0000_0005, 0, 0);
        run_txn(1'b0, 32'd3, 32'h0, 0, 0);

        // VGA write with three cycles of backpressure
        run_txn(1'b1, VBASE + 32'h20, 32'h0000_ABCD, 3, 0);

        // Error cases, then confirm RAM untouched
        run_txn(1'b0, VBASE, 32'h0, 0, 0);
        run_txn(1'b1, 32'h0800_0000, 32'hDEAD_BEEF, 0, 0);
        run_txn(1'b0, 32'd3, 32'h0, 0, 0);

        // req held high long after done
        run_txn(1'b0, 32'd3, 32'h0, 0, 10);

        // Reset while waiting on RAM read latency
        drive_req(1'b0, 32'd3, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        check_outputs_zero("rst_ram_rd");
        rst          = 1'b0;
        mobo_ctrl[0] = 1'b0;
        last_rdata   = '0;
        step();

        // Reset while a VGA write is stalled
        begin
            vga_exp_t v;
            bit       got;
            v.off       = 16'h0040;
            v.data      = 32'h1234_5678;
            v.we_cycles = -1;
            vga_exp_q.push_back(v);
            vga_ready = 1'b0;
            drive_req(1'b1, VBASE + 32'h40, 32'h1234_5678);
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (vga_we) begin
                    got = 1'b1;
                    break;
                end
            end
            check("abort_vga_we_seen", 32'(got), 32'd1);
            step();
            rst = 1'b1;
            step();
            check_outputs_zero("rst_vga");
            rst          = 1'b0;
            mobo_ctrl[0] = 1'b0;
            vga_exp_q.delete();
            vga_ready    = 1'b1;
            repeat (4) step();
            check("no_vga_after_rst", 32'(vga_we), 32'd0);
            check("idle_after_rst", mobo_stat, 32'd0);
        end
        run_txn(1'b0, 32'd3, 32'h0, 0, 0);

        // Boundaries: top RAM word valid, first word past RAM is an error
        run_txn(1'b1, 32'd1023, 32'hCAFE_F00D, 0, 0);
        run_txn(1'b0, 32'd1023, 32'h0, 0, 0);
        run_txn(1'b1, 32'd1024, 32'h1111_2222, 0, 0);
        run_txn(1'b0, 32'd1024, 32'h0, 0, 0);
        run_txn(1'b1, VBASE + 32'hFFFF, 32'h7777_8888, 1, 0);
        run_txn(1'b1, VBASE + 32'h1_0000, 32'h9999_AAAA, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int          k;
            logic [31:0] a;
            k = int'($urandom_range(0, 5));
            case (k)
                0: run_txn(1'b1, 32'($urandom_range(0, 1023)), $urandom(), 0,
                           int'($urandom_range(0, 2)));
                1, 2: begin
                    a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                    run_txn(1'b0, a, 32'h0, 0, int'($urandom_range(0, 2)));
                end
                3: run_txn(1'b1, VBASE + 32'($urandom_range(0, 65535)), $urandom(),
                           int'($urandom_range(0, 3)), 0);
                4: run_txn(1'b0, VBASE + 32'($urandom_range(0, 65535)), 32'h0, 0, 0);
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        a = 32'd1024 + 32'($urandom_range(0, 32'hF000));
                    else
                        a = 32'h8000_0000 | $urandom();
                    run_txn(1'($urandom_range(0, 1)), a, $urandom(), 0, 0);
                end
            endcase
        end

        repeat (3) step();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("vga_q_drained", 32'(vga_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_mobo_bus_responder
